// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers.
// Everything here is pure combinational math, usable from any module.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DRAIN
    } aes_state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_round_step.sv
// One combinational AES-128 encryption round plus the matching key-schedule step.
// Byte i of a block sits at bits [127-8*i -: 8]; column c holds bytes 4c..4c+3.
module aes_round_step
    import aes_pkg::*;
(
    input  block_t     st,
    input  block_t     rk,
    input  logic [7:0] rcon,
    input  logic       final_round,
    output block_t     st_next,
    output block_t     rk_next
);

    block_t      sub_b;
    block_t      shift_r;
    block_t      mix_c;
    logic [31:0] temp;
    logic [31:0] w0, w1, w2, w3;

    always_comb begin
        sub_b   = '0;
        shift_r = '0;
        mix_c   = '0;
        for (int i = 0; i < 16; i++) begin
            sub_b[127 - 8*i -: 8] = sbox(st[127 - 8*i -: 8]);
        end
        // Row r of column c takes row r of column (c + r) mod 4
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_r[127 - 8*(4*c + r) -: 8] = sub_b[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_c[127 - 32*c -: 32] = mix_column(shift_r[127 - 32*c -: 32]);
        end
    end

    always_comb begin
        temp = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])}
               ^ {rcon, 24'h000000};
        w0 = rk[127:96] ^ temp;
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
    end

    assign rk_next = {w0, w1, w2, w3};
    assign st_next = (final_round ? shift_r : mix_c) ^ rk_next;

endmodule

// File: rtl/aes128_enc_stream.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion,
// ciphertext streamed out in OUT_W-bit beats under valid/ready handshakes.
module aes128_enc_stream
    import aes_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [127:0]     in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int NBEATS = 128 / OUT_W;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if (!(OUT_W == 8 || OUT_W == 16 || OUT_W == 32 || OUT_W == 64 || OUT_W == 128)) begin : g_bad_width
        $fatal(1, "aes128_enc_stream: OUT_W must be 8, 16, 32, 64 or 128");
    end

    aes_state_e    state, state_n;
    block_t        st, rk, st_next, rk_next;
    logic [7:0]    rcon;
    logic [3:0]    round;
    logic [BW-1:0] beat;
    logic [6:0]    lo;
    logic          final_round;
    logic          last_beat;

    assign final_round = (round == 4'(NR));
    assign last_beat   = (beat == BW'(NBEATS - 1));

    aes_round_step u_round_step (
        .st          (st),
        .rk          (rk),
        .rcon        (rcon),
        .final_round (final_round),
        .st_next     (st_next),
        .rk_next     (rk_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = ROUND;
            ROUND:   if (final_round) state_n = DRAIN;
            DRAIN:   if (out_ready && last_beat) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= '0;
            rk    <= '0;
            rcon  <= 8'h00;
            round <= 4'd0;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= in_data ^ in_key;
                        rk    <= in_key;
                        rcon  <= 8'h01;
                        round <= 4'd1;
                    end
                end
                ROUND: begin
                    st    <= st_next;
                    rk    <= rk_next;
                    rcon  <= xtime(rcon);
                    round <= round + 4'd1;
                    if (final_round) beat <= '0;
                end
                DRAIN: begin
                    if (out_ready) beat <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // st only changes outside DRAIN, so the selected beat holds steady under backpressure
    always_comb begin
        lo       = MSB_FIRST ? 7'((NBEATS - 1 - int'(beat)) * OUT_W) : 7'(int'(beat) * OUT_W);
        out_data = (state == DRAIN) ? st[lo +: OUT_W] : '0;
    end

    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && last_beat;
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_aes128_enc_stream.sv
// Bench for aes128_enc_stream: four instances (8/MSB, 128, 32, 8/LSB) checked
// against known-answer vectors and a byte-level AES reference model.
module tb_aes128_enc_stream;

    localparam int ND = 4;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        int           d;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           rmode;
        bit           hold;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv   [ND];
    logic [127:0] idat [ND];
    logic [127:0] ikey [ND];
    logic         ordy [ND];
    logic         irdy [ND];
    logic         ov   [ND];
    logic         olast[ND];
    logic         bsy  [ND];
    logic [127:0] od   [ND];

    int checks   = 0;
    int failures = 0;
    logic [7:0] sbm [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int W = (g == 1) ? 128 : (g == 2) ? 32 : 8;
        localparam bit M = (g == 3) ? 1'b0 : 1'b1;
        logic [W-1:0] data;
        aes128_enc_stream #(.OUT_W(W), .MSB_FIRST(M)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (irdy[g]),
            .in_data   (idat[g]),
            .in_key    (ikey[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (data),
            .out_last  (olast[g]),
            .busy      (bsy[g])
        );
        assign od[g] = 128'(data);
    end

    function automatic int wv(input int d);
        return (d == 1) ? 128 : (d == 2) ? 32 : 8;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbm[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] k [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [7:0] x;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127 - 8*i -: 8];
            s[i] = pt[127 - 8*i -: 8] ^ k[i];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = k[i - 4 + j];
            if (i % 16 == 0) begin
                x = tmp[0];
                tmp[0] = sbm[tmp[1]] ^ rc;
                tmp[1] = sbm[tmp[2]];
                tmp[2] = sbm[tmp[3]];
                tmp[3] = sbm[x];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) k[i + j] = k[i - 16 + j] ^ tmp[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = sbm[s[4*((c + row) % 4) + row]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    if (r < 10)
                        s[4*c + row] = gmul(t[4*c + row], 8'h02) ^ gmul(t[4*c + (row + 1) % 4], 8'h03)
                                       ^ t[4*c + (row + 2) % 4] ^ t[4*c + (row + 3) % 4];
                    else
                        s[4*c + row] = t[4*c + row];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[16*r + i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One full transaction on instance d; called and returning on a falling edge.
    // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run_block(input int d, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp_ct, input int rmode, input bit hold);
        int w, nbeats, k, nb, dc;
        bit r, stalled;
        logic [127:0] ct, pd;
        logic pl;
        w = wv(d); nbeats = 128 / w;
        ct = '0; pd = '0; pl = 1'b0; nb = 0; dc = 0; stalled = 1'b0;
        k = 0;
        while (!irdy[d] && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_idle", 128'(irdy[d]), 128'd1);
        iv[d] = 1'b1; idat[d] = pt; ikey[d] = key;
        @(negedge clk);
        iv[d] = hold;
        k = 0;
        while (!ov[d] && k < 40) begin
            if (hold) begin
                idat[d] = rnd128(); ikey[d] = rnd128();
                check("ignore_in_valid", 128'(irdy[d]), 128'd0);
            end
            k++;
            @(negedge clk);
        end
        check("latency", 128'(k), 128'd10);
        while (ov[d] && dc < 400) begin
            if (stalled) begin
                check("stable_data", od[d], pd);
                check("stable_last", 128'(olast[d]), 128'(pl));
            end
            check("out_last", 128'(olast[d]), 128'(nb == nbeats - 1));
            if (hold) begin
                idat[d] = rnd128(); ikey[d] = rnd128();
            end
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (dc % 4 == 0 || dc % 4 == 3) : 1'($urandom_range(0, 1));
            ordy[d] = r;
            if (r) begin
                if (d == 3) ct = ct | (od[d] << (nb * w));
                else        ct = (ct << w) | od[d];
                nb++;
            end
            stalled = !r; pd = od[d]; pl = olast[d];
            dc++;
            @(negedge clk);
        end
        iv[d] = 1'b0; ordy[d] = 1'b0;
        check("ciphertext", ct, exp_ct);
        check("beat_count", 128'(nb), 128'(nbeats));
        check("in_ready_after", 128'(irdy[d]), 128'd1);
        check("busy_after", 128'(bsy[d]), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [6];
        logic [127:0] key, pt;
        tv[0] = '{0, C1_KEY, C1_PT, C1_CT, 0, 1'b0};
        tv[1] = '{1, B_KEY,  B_PT,  B_CT,  0, 1'b0};
        tv[2] = '{2, C1_KEY, C1_PT, C1_CT, 1, 1'b0};
        tv[3] = '{3, C1_KEY, C1_PT, C1_CT, 0, 1'b0};
        tv[4] = '{1, C1_KEY, C1_PT, C1_CT, 2, 1'b0};
        tv[5] = '{0, B_KEY,  B_PT,  B_CT,  0, 1'b1};

        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            iv[d] = 1'b0; idat[d] = '0; ikey[d] = '0; ordy[d] = 1'b0;
        end
        build_sbox();
        #1;
        for (int d = 0; d < ND; d++) begin
            check("rst_in_ready", 128'(irdy[d]), 128'd1);
            check("rst_busy", 128'(bsy[d]), 128'd0);
            check("rst_out_valid", 128'(ov[d]), 128'd0);
            check("rst_out_last", 128'(olast[d]), 128'd0);
            check("rst_out_data", od[d], 128'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_block(tv[i].d, tv[i].key, tv[i].pt, tv[i].ct, tv[i].rmode, tv[i].hold);
        end

        // Follow-up block after the held-in_valid run must still be correct
        run_block(0, C1_KEY, C1_PT, C1_CT, 0, 1'b0);

        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 5; i++) begin
                key = rnd128(); pt = rnd128();
                run_block(d, key, pt, aes_ref(key, pt), 2, 1'($urandom_range(0, 1)));
            end
        end

        // Reset while the core is working on round 5
        iv[0] = 1'b1; idat[0] = C1_PT; ikey[0] = C1_KEY;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 128'(bsy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(ov[0]), 128'd0);
        check("mid_rst_busy", 128'(bsy[0]), 128'd0);
        check("mid_rst_in_ready", 128'(irdy[0]), 128'd1);
        check("mid_rst_out_data", od[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("no_discarded_emit", 128'(ov[0]), 128'd0);
        end
        run_block(0, C1_KEY, C1_PT, C1_CT, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
